// File: rtl/aes_pkg.sv
// Shared AES definitions: forward/inverse S-box tables, state type, byte extraction
// and the SubBytes engine state encoding.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sbe_state_e;

  localparam logic [7:0] sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte k sits at bits [127-8k -: 8], so FIPS-197 hex strings read left to right.
  function automatic logic [7:0] aes_byte(input aes_state_t state, input logic [3:0] k);
    return state[7'(8 * (15 - int'(k))) +: 8];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lookup, forward or inverse selected per block.
module sbox_lane
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] in,
  output logic [7:0] out
);

  assign out = inv ? inv_sbox[in] : sbox[in];

endmodule

// File: rtl/sub_bytes_engine.sv
// Handshaked AES SubBytes: LANES S-box lookups per cycle over a captured 128-bit state,
// finishing a block in 16/LANES beats.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
    $fatal(1, "sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sbe_state_e      state_q;
  aes_state_t      src_q;
  aes_state_t      res_q;
  aes_state_t      res_nxt;
  logic            inv_q;
  logic [BW-1:0]   beat_q;
  logic [3:0]      lane_idx [LANES];
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // Byte positions handled by each lane in the current beat.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      lane_idx[l] = 4'(int'(beat_q) * int'(LANES) + l);
      lane_in[l]  = aes_byte(src_q, lane_idx[l]);
    end
  end

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    sbox_lane u_lane (
      .inv (inv_q),
      .in  (lane_in[l]),
      .out (lane_out[l])
    );
  end

  // Write lane results back into their own byte slots; other bytes hold.
  always_comb begin
    res_nxt = res_q;
    for (int l = 0; l < int'(LANES); l++) begin
      res_nxt[7'(8 * (15 - int'(lane_idx[l]))) +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      res_q     <= '0;
      inv_q     <= 1'b0;
      beat_q    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q   <= in_state;
            inv_q   <= in_inv;
            beat_q  <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q <= res_nxt;
          if (beat_q == BW'(BEATS - 1)) begin
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= DONE;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              src_q   <= in_state;
              inv_q   <= in_inv;
              beat_q  <= '0;
              busy    <= 1'b1;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Retiring a finished block frees the engine on the same edge.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_state = res_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: five instances (LANES 4,1,2,8,16) checked against an
// S-box model derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_engine;

  localparam int NI = 5;

  function automatic int unsigned lanes_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic         busy      [NI];
  logic [127:0] out_state [NI];
  logic         in_inv;
  logic [127:0] in_state;

  int n_vec = 0;
  int n_err = 0;

  bit [7:0] fwd_t [256];
  bit [7:0] inv_t [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_engine #(.LANES(lanes_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_inv    (in_inv),
      .in_state  (in_state),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] p = 8'h00;
    bit       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box = affine(x^254) in GF(2^8); inverse table is the reverse mapping.
  task automatic build_tables();
    bit [7:0] r, s, rot;
    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      for (int e = 0; e < 254; e++) r = gmul(r, 8'(x));
      s   = r;
      rot = r;
      for (int n = 0; n < 4; n++) begin
        rot = {rot[6:0], rot[7]};
        s ^= rot;
      end
      s ^= 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    for (int k = 0; k < 16; k++) begin
      b = st[127 - 8*k -: 8];
      r[127 - 8*k -: 8] = inv ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_out(input int i, input string tag);
    int cyc = 0;
    while (!out_valid[i] && cyc < 100) begin
      tick();
      cyc++;
    end
    check($sformatf("%s_latency_l%0d", tag, lanes_of(i)), 128'(cyc), 128'(16 / lanes_of(i)));
  endtask

  task automatic run_block(input int i, input logic [127:0] d, input logic inv,
                           input logic [127:0] exp, input string tag);
    int cyc = 0;
    while (!in_ready[i] && cyc < 50) begin
      tick();
      cyc++;
    end
    check({tag, "_in_ready"}, 128'(in_ready[i]), 128'(1));
    in_valid[i] = 1'b1;
    in_state    = d;
    in_inv      = inv;
    tick();
    in_valid[i] = 1'b0;
    in_state    = rand128();
    in_inv      = 1'($urandom);
    check({tag, "_busy"}, 128'(busy[i]), 128'(1));
    wait_out(i, tag);
    check({tag, "_data"}, out_state[i], exp);
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
    check({tag, "_retired"}, 128'(out_valid[i]), 128'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_in_ready_%0d", tag, i),  128'(in_ready[i]),  128'(1));
      check($sformatf("%s_out_valid_%0d", tag, i), 128'(out_valid[i]), 128'(0));
      check($sformatf("%s_busy_%0d", tag, i),      128'(busy[i]),      128'(0));
      check($sformatf("%s_out_state_%0d", tag, i), out_state[i],       128'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d, d2, exp, hold;
    logic         inv2;
    logic         saw;

    build_tables();
    rst_n    = 1'b0;
    in_inv   = 1'b0;
    in_state = '0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (3) tick();
    check_reset_vals("por");
    rst_n = 1'b1;
    tick();

    // Known-answer vectors on LANES=4
    run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, "kat_fwd");
    run_block(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, "kat_inv");
    run_block(0, 128'h0, 1'b1, {16{8'h52}}, "zero_inv");
    run_block(0, 128'h0, 1'b0, {16{8'h63}}, "zero_fwd");

    // Backpressure, then retire and accept on the same edge
    d = rand128();
    in_valid[0] = 1'b1;
    in_state    = d;
    in_inv      = 1'b0;
    tick();
    d2   = rand128();
    inv2 = 1'b1;
    in_valid[0] = 1'b1;
    in_state    = d2;
    in_inv      = inv2;
    wait_out(0, "bp");
    exp  = model(d, 1'b0);
    hold = out_state[0];
    check("bp_data", hold, exp);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_valid", 128'(out_valid[0]), 128'(1));
      check("bp_stable", out_state[0], exp);
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready[0]), 128'(1));
    tick();
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    in_state     = rand128();
    check("b2b_retired", 128'(out_valid[0]), 128'(0));
    check("b2b_busy", 128'(busy[0]), 128'(1));
    wait_out(0, "b2b");
    check("b2b_data", out_state[0], model(d2, inv2));
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Reset in RUN on LANES=1 at beat 2
    d = rand128();
    in_valid[1] = 1'b1;
    in_state    = d;
    in_inv      = 1'b0;
    tick();
    in_valid[1] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      in_state     = rand128();
      in_inv       = 1'($urandom);
      in_valid[1]  = 1'($urandom);
      out_ready[1] = 1'($urandom);
      tick();
      check_reset_vals("mid_rst");
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    rst_n        = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid[1]) saw = 1'b1;
    end
    check("mid_rst_no_output", 128'(saw), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready[1]), 128'(1));
    d = rand128();
    run_block(1, d, 1'b1, model(d, 1'b1), "post_rst");

    // Sweep: every byte value in both modes on every LANES, then random blocks
    for (int i = 0; i < NI; i++) begin
      for (int m = 0; m < 2; m++) begin
        for (int j = 0; j < 16; j++) begin
          for (int k = 0; k < 16; k++) d[127 - 8*k -: 8] = 8'(16*j + k);
          run_block(i, d, 1'(m), model(d, 1'(m)), $sformatf("sweep_l%0d_m%0d", lanes_of(i), m));
        end
      end
      for (int r = 0; r < 6; r++) begin
        d    = rand128();
        inv2 = 1'($urandom);
        run_block(i, d, inv2, model(d, inv2), $sformatf("rand_l%0d", lanes_of(i)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
